// File: rtl/inst_fetch.sv
`default_nettype none
// ==========================================================================
// inst_fetch : PC + one-word direct-mapped I-cache, byte-serial miss refill
// Revision   : 1.0
// ==========================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_state,
  input  logic        b_flag_i,
  input  logic [31:0] b_target_i,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_stall_req
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state, state_next;
  logic [31:0]      pc;
  logic [1:0]       byte_cnt;
  logic [31:0]      word_buf;
  logic [ICACHE_LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [ICACHE_LINES];
  logic [31:0]      data_arr [ICACHE_LINES];

  logic             stall;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             last_byte;
  logic             fill_we;
  logic [31:0]      word;
  logic [31:0]      redirect_pc;
  logic             unused_bits;

  assign stall       = stall_state[0];
  assign idx         = pc[IDX_W+1:2];
  assign tag         = pc[31:IDX_W+2];
  assign hit         = valid[idx] && (tag_arr[idx] == tag);
  assign last_byte   = (state == S_FETCH) && mem_ready && (byte_cnt == 2'd3);
  assign fill_we     = last_byte && !b_flag_i && !rst;
  assign word        = {mem_rdata, word_buf[23:0]};
  assign redirect_pc = {b_target_i[31:2], 2'b00};
  assign unused_bits = ^{stall_state[5:1], b_target_i[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; a redirect overrides everything below reset
  always_comb begin
    state_next = state;
    if (b_flag_i) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (!stall && !hit) state_next = S_FETCH;
        S_FETCH: if (last_byte)      state_next = stall ? S_HOLD : S_IDLE;
        S_HOLD:  if (!stall)         state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    mem_req      = 1'b0;
    mem_addr     = 32'h0;
    if_stall_req = 1'b0;
    if (state == S_FETCH) begin
      mem_req      = 1'b1;
      mem_addr     = {pc[31:2], byte_cnt};
      if_stall_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      byte_cnt <= 2'd0;
      valid    <= '0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else if (b_flag_i) begin
      pc       <= redirect_pc;
      byte_cnt <= 2'd0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!stall) begin
            if (hit) begin
              if_pc   <= pc;
              if_inst <= data_arr[idx];
              pc      <= pc + 32'd4;
            end else begin
              byte_cnt <= 2'd0;
              if_pc    <= 32'h0;
              if_inst  <= 32'h0;
            end
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= mem_rdata;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              valid[idx] <= 1'b1;
              if (!stall) begin
                if_pc   <= pc;
                if_inst <= word;
                pc      <= pc + 32'd4;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_pc   <= pc;
            if_inst <= word_buf;
            pc      <= pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage is qualified by valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ==========================================================================
// tb_inst_fetch : scoreboard bench with a byte-serial memory responder
// Revision      : 1.0
// ==========================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_state;
  logic        b_flag_i;
  logic [31:0] b_target_i;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_req;

  inst_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_state (stall_state),
    .b_flag_i    (b_flag_i),
    .b_target_i  (b_target_i),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_stall_req(if_stall_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int budget = 0;
  logic [7:0]  mem [1024];
  logic [31:0] exp_addr [$];
  logic [63:0] exp_inst [$];   // {pc, inst}
  logic [31:0] prev_pc = 32'h0, prev_inst = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one ready pulse per byte, at most `budget` bytes released
  always @(posedge clk) begin
    #2;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_req && budget > 0) begin
      mem_rdata = mem[mem_addr[9:0]];
      mem_ready = 1'b1;
      budget--;
    end
  end

  // Address monitor: every accepted byte must match the expected address
  always @(negedge clk) begin
    if (mem_ready && mem_req) begin
      if (exp_addr.size() == 0) chk("unexpected_byte_addr", mem_addr, 32'hDEAD_DEAD);
      else chk("byte_addr", mem_addr, exp_addr.pop_front());
    end
  end

  // Instruction monitor: a new non-bubble {if_pc,if_inst} is a presentation
  always @(negedge clk) begin
    if (!rst && if_inst != 32'h0 && (if_inst != prev_inst || if_pc != prev_pc)) begin
      if (exp_inst.size() == 0) begin
        chk("unexpected_inst", if_inst, 32'hDEAD_DEAD);
      end else begin
        logic [63:0] e;
        e = exp_inst.pop_front();
        chk("if_pc", if_pc, e[63:32]);
        chk("if_inst", if_inst, e[31:0]);
      end
    end
    prev_pc   = if_pc;
    prev_inst = if_inst;
  end

  task automatic push_word(input logic [31:0] a, input logic [31:0] inst);
    for (int i = 0; i < 4; i++) exp_addr.push_back(a + 32'(i));
    exp_inst.push_back({a, inst});
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_inst.size() != 0 || exp_addr.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({name, "_timeout"}, 32'(exp_inst.size()), 32'h0);
  endtask

  task automatic wait_consumed(input string name);
    int n = 0;
    while ((budget != 0 || mem_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({name, "_timeout"}, 32'(budget), 32'h0);
  endtask

  task automatic redirect(input logic [31:0] t);
    b_flag_i   = 1'b1;
    b_target_i = t;
    @(negedge clk);
    b_flag_i   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
    mem[4]     = 8'hAA; mem[5]     = 8'hBB; mem[6]     = 8'hCC; mem[7]     = 8'hDD;
    mem[10'h40] = 8'h33; mem[10'h41] = 8'h85; mem[10'h42] = 8'hA5; mem[10'h43] = 8'h00;
    mem[10'h100] = 8'h93; mem[10'h101] = 8'h00; mem[10'h102] = 8'h10; mem[10'h103] = 8'h00;
    mem[10'h104] = 8'hB7; mem[10'h105] = 8'h12; mem[10'h106] = 8'h34; mem[10'h107] = 8'h56;
    mem[10'h3FC] = 8'h6F; mem[10'h3FD] = 8'h00; mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h00;

    rst = 1'b1; stall_state = 6'b101100; b_flag_i = 1'b0; b_target_i = 32'h0;
    mem_ready = 1'b0; mem_rdata = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset_if_pc", if_pc, 32'h0);
    chk("reset_if_inst", if_inst, 32'h0);
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset_stall_req", {31'h0, if_stall_req}, 32'h0);

    // Cold miss at 0
    push_word(32'h0, 32'h0010_0513);
    budget = 4;
    rst = 1'b0;
    @(negedge clk);
    chk("cold_mem_req", {31'h0, mem_req}, 32'h1);
    chk("cold_stall_req", {31'h0, if_stall_req}, 32'h1);
    chk("cold_mem_addr", mem_addr, 32'h0);
    wait_empty("cold_fill");

    // Hit on revisit of 0
    exp_inst.push_back({32'h0, 32'h0010_0513});
    redirect(32'h0);
    @(negedge clk);
    chk("hit_no_mem_req", {31'h0, mem_req}, 32'h0);
    chk("hit_no_stall_req", {31'h0, if_stall_req}, 32'h0);
    wait_empty("hit");

    // Redirect after two bytes of the fetch at 4
    exp_addr.push_back(32'h4); exp_addr.push_back(32'h5);
    budget = 2;
    wait_consumed("partial");
    redirect(32'h0000_0103);
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("redirect_mem_req", {31'h0, mem_req}, 32'h1);
    chk("redirect_mem_addr", mem_addr, 32'h100);

    // Stall lands on the 4th byte, released three cycles later
    for (int i = 0; i < 3; i++) exp_addr.push_back(32'h100 + 32'(i));
    budget = 3;
    wait_consumed("pre_stall");
    stall_state[0] = 1'b1;
    exp_addr.push_back(32'h103);
    budget = 1;
    wait_consumed("stall_byte");
    for (int i = 0; i < 3; i++) begin
      chk("hold_if_inst", if_inst, 32'h0);
      chk("hold_mem_req", {31'h0, mem_req}, 32'h0);
      if (i < 2) @(negedge clk);
    end
    chk("hold_stall_req", {31'h0, if_stall_req}, 32'h0);
    exp_inst.push_back({32'h100, 32'h0010_0093});
    stall_state[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_hold_mem_addr", mem_addr, 32'h104);
    push_word(32'h104, 32'h5634_12B7);
    budget = 4;
    wait_empty("fill_104");

    // Conflict eviction: 0x40 shares index 0 with 0
    push_word(32'h40, 32'h00A5_8533);
    budget = 4;
    redirect(32'h40);
    wait_empty("fill_40");

    // Reset after three bytes of the fetch at 0x44
    for (int i = 0; i < 3; i++) exp_addr.push_back(32'h44 + 32'(i));
    budget = 3;
    wait_consumed("pre_reset");
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midreset_stall_req", {31'h0, if_stall_req}, 32'h0);
    chk("midreset_if_inst", if_inst, 32'h0);
    chk("midreset_if_pc", if_pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_mem_req", {31'h0, mem_req}, 32'h1);
    chk("post_reset_mem_addr", mem_addr, 32'h0);
    redirect(32'h40);
    @(negedge clk);
    chk("valid_cleared_mem_req", {31'h0, mem_req}, 32'h1);
    chk("valid_cleared_mem_addr", mem_addr, 32'h40);

    // Eviction check needs line 0x40 refilled, then 0 must miss
    push_word(32'h40, 32'h00A5_8533);
    budget = 4;
    wait_empty("refill_40");
    redirect(32'h0);
    @(negedge clk);
    chk("evict_mem_req", {31'h0, mem_req}, 32'h1);
    chk("evict_mem_addr", mem_addr, 32'h0);

    // Wrap at top of address space; low target bits ignored
    push_word(32'hFFFF_FFFC, 32'h0000_006F);
    budget = 4;
    redirect(32'hFFFF_FFFF);
    wait_empty("fill_wrap");
    @(negedge clk);
    chk("wrap_mem_addr", mem_addr, 32'h0);
    chk("wrap_mem_req", {31'h0, mem_req}, 32'h1);

    chk("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
    chk("inst_queue_empty", 32'(exp_inst.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
